keccak_seq_ctrl: RTL and testbench

- Sequencer sitting between a streaming host interface and keccak_top; takes the place of the bench-driven command flow.
- Per job: pulses init, streams nblk × WORDS_PER_BLK 16-bit words into the core with the load/ack handshake, then fetches DIGEST_WORDS words with the fetch/ack handshake and presents them on a valid/ready output stream.
- Watchdog on every core handshake; status via busy/done/err.

---
 rtl/keccak_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_keccak_seq_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_seq_ctrl.sv
// Job sequencer between a streaming host and keccak_top: init, absorb, squeeze, stream out.
// Optional cycle counter enabled by defining KECCAK_SEQ_CTRL_CYCCNT_EN.
module keccak_seq_ctrl #(
  parameter int WORDS_PER_BLK = 68,
  parameter int DIGEST_WORDS  = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  nblk,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [15:0] m_data,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] cyc_count,
  output logic        core_init,
  output logic        core_load,
  output logic        core_fetch,
  output logic [15:0] core_idata,
  input  logic        core_ack,
  input  logic [15:0] core_odata
);

  // state    | meaning
  // ---------+-----------------------------------------------
  // ST_IDLE  | waiting for start
  // ST_INIT  | core_init strobe, one cycle
  // ST_LWAIT | s_ready high, waiting for an input word
  // ST_LOAD  | core_load high until core_ack
  // ST_FETCH | core_fetch high until core_ack
  // ST_OUT   | m_valid high until m_ready
  // ST_DONE  | done pulse, one cycle
  // ST_ERR   | core handshake timed out, waits for start
  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_LWAIT, ST_LOAD, ST_FETCH, ST_OUT, ST_DONE, ST_ERR
  } state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DC_W = $clog2(DIGEST_WORDS + 1);
  localparam logic [15:0]     WPB     = 16'(WORDS_PER_BLK);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DIGEST_WORDS - 1);

  state_t          state_q, state_d;
  logic [15:0]     words_left_q;
  logic [DC_W-1:0] dig_cnt_q;
  logic [WD_W-1:0] wd_q;
  logic            job_go, job_zero;
  logic            wd_expired;

  // Watchdog is a down-counter; terminal count with no ack means the core hung.
  assign wd_expired = (wd_q == '0) && !core_ack;

  always_comb begin
    state_d  = state_q;
    job_go   = 1'b0;
    job_zero = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          if (nblk != 8'd0) begin
            state_d = ST_INIT;
            job_go  = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            job_zero = 1'b1;
          end
        end
      end
      ST_INIT:  state_d = ST_LWAIT;
      ST_LWAIT: if (s_valid) state_d = ST_LOAD;
      ST_LOAD: begin
        if (core_ack) state_d = (words_left_q == 16'd1) ? ST_FETCH : ST_LWAIT;
        else if (wd_expired) state_d = ST_ERR;
      end
      ST_FETCH: begin
        if (core_ack) state_d = ST_OUT;
        else if (wd_expired) state_d = ST_ERR;
      end
      ST_OUT:   if (m_ready) state_d = (dig_cnt_q == DC_LAST) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_left_q <= '0;
      dig_cnt_q    <= '0;
      wd_q         <= '0;
    end else begin
      if (job_go)
        words_left_q <= {8'd0, nblk} * WPB;
      else if (state_q == ST_LOAD && core_ack)
        words_left_q <= words_left_q - 16'd1;

      if (job_go)
        dig_cnt_q <= '0;
      else if (state_q == ST_OUT && m_ready)
        dig_cnt_q <= dig_cnt_q + DC_W'(1);

      if ((state_d == ST_LOAD || state_d == ST_FETCH) && state_d != state_q)
        wd_q <= WD_LOAD;
      else if ((state_q == ST_LOAD || state_q == ST_FETCH) && !core_ack && wd_q != '0)
        wd_q <= wd_q - WD_W'(1);
    end
  end

  // Every output is a flop decoded from the next state, so reset clears them all at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_init  <= 1'b0;
      core_load  <= 1'b0;
      core_fetch <= 1'b0;
      core_idata <= '0;
    end else begin
      s_ready    <= (state_d == ST_LWAIT);
      m_valid    <= (state_d == ST_OUT);
      busy       <= !(state_d == ST_IDLE || state_d == ST_ERR);
      done       <= (state_d == ST_DONE) || job_zero;
      err        <= (state_d == ST_ERR);
      core_init  <= (state_d == ST_INIT);
      core_load  <= (state_d == ST_LOAD);
      core_fetch <= (state_d == ST_FETCH);
      if (state_q == ST_LWAIT && s_valid)
        core_idata <= s_data;
      if (state_q == ST_FETCH && core_ack)
        m_data <= core_odata;
    end
  end

`ifdef KECCAK_SEQ_CTRL_CYCCNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cyc_q <= '0;
    else if ((state_q == ST_IDLE || state_q == ST_ERR) && start)
      cyc_q <= '0;
    else if (busy && cyc_q != 32'hFFFF_FFFF)
      cyc_q <= cyc_q + 32'd1;
  end

  assign cyc_count = cyc_q;
`else
  assign cyc_count = 32'd0;
`endif

endmodule

// File: tb/tb_keccak_seq_ctrl.sv
// Directed bench for keccak_seq_ctrl with a behavioural keccak_top handshake model.
module tb_keccak_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  nblk;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic        busy, done, err;
  logic [31:0] cyc_count;
  logic        core_init, core_load, core_fetch;
  logic [15:0] core_idata;
  logic        core_ack;
  logic [15:0] core_odata;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  keccak_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nblk(nblk),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err), .cyc_count(cyc_count),
    .core_init(core_init), .core_load(core_load), .core_fetch(core_fetch),
    .core_idata(core_idata), .core_ack(core_ack), .core_odata(core_odata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation state
  int          init_cnt, fetch_hs, done_cnt, busy_cycles;
  logic [15:0] load_log[$];
  logic [15:0] out_log[$];
  logic [15:0] stall_samples[$];

  // Stimulus / model control
  int   src_idx, src_total;
  bit   src_en, src_toggle, src_acc, phase;
  bit   snk_en, snk_acc;
  logic [15:0] snk_word;
  int   stall_word = -1;
  int   stall_left = 0;
  int   ack_block_idx = -1;
  int   odata_idx;
  bit   seen, stb, blocked;

  function automatic logic [15:0] exp_odata(input int k);
    return 16'hC000 ^ (16'(k) * 16'h0731);
  endfunction

  // keccak_top model: ack one cycle after a strobe is first seen
  initial begin
    core_ack = 1'b0;
    core_odata = '0;
    seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        core_ack = 1'b0;
        seen = 1'b0;
      end else begin
        stb = core_load || core_fetch;
        blocked = core_load && (load_log.size() == ack_block_idx);
        if (stb && seen && !core_ack && !blocked) begin
          if (core_fetch) begin
            core_odata = exp_odata(odata_idx);
            odata_idx++;
          end
          core_ack = 1'b1;
        end else begin
          core_ack = 1'b0;
        end
        seen = stb;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_init) init_cnt++;
      if (core_load && core_ack) load_log.push_back(core_idata);
      if (core_fetch && core_ack) fetch_hs++;
      if (done) done_cnt++;
      if (busy) busy_cycles++;
    end
  end

  // Input word source
  initial begin
    s_valid = 1'b0;
    s_data = '0;
    src_acc = 1'b0;
    phase = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) src_acc = 1'b0;
      if (src_acc) src_idx++;
      s_valid = src_en && (src_idx < src_total) && (!src_toggle || phase);
      s_data = s_valid ? 16'(src_idx) : 16'hFFFF;
      src_acc = s_valid && s_ready;
      phase = !phase;
    end
  end

  // Digest sink with an optional stall on one word
  initial begin
    m_ready = 1'b0;
    snk_acc = 1'b0;
    snk_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) snk_acc = 1'b0;
      if (snk_acc) out_log.push_back(snk_word);
      if (m_valid && out_log.size() == stall_word && stall_left > 0) begin
        m_ready = 1'b0;
        stall_samples.push_back(m_data);
        stall_left--;
      end else begin
        m_ready = snk_en;
      end
      snk_acc = m_valid && m_ready;
      snk_word = m_data;
    end
  end

  task automatic clear_logs();
    init_cnt = 0; fetch_hs = 0; done_cnt = 0; busy_cycles = 0;
    load_log.delete(); out_log.delete(); stall_samples.delete();
    odata_idx = 0; src_idx = 0; src_total = 0; src_en = 1'b0;
    stall_word = -1; stall_left = 0;
  endtask

  task automatic start_job(input logic [7:0] nb, input bit toggle);
    src_total = int'(nb) * 68;
    src_toggle = toggle;
    src_idx = 0;
    src_en = 1'b1;
    snk_en = 1'b1;
    @(negedge clk);
    nblk = nb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; nblk = '0; snk_en = 1'b0;
    clear_logs();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({s_ready, m_valid, m_data, busy, done, err, cyc_count, core_init, core_load,
         core_fetch, core_idata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero output in reset (busy=%b idata=%h)", busy, core_idata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, s_ready, core_init} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: busy/s_ready/init=%b want 000", {busy, s_ready, core_init});
    end
  endtask

  task automatic test_single_block();
    bit ok;
    int first_bad;
    clear_logs();
    start_job(8'd1, 1'b0);
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t1_done_timeout: no done within bound, want done"); end
    repeat (3) @(negedge clk);
    total++;
    if (init_cnt !== 1) begin bad++; $display("FAIL t1_init_cnt: got %0d want 1", init_cnt); end
    total++;
    if (load_log.size() !== 68) begin bad++; $display("FAIL t1_load_cnt: got %0d want 68", load_log.size()); end
    first_bad = -1;
    foreach (load_log[i]) if (first_bad < 0 && load_log[i] !== 16'(i)) first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL t1_load_seq: word %0d got %h want %h", first_bad, load_log[first_bad], 16'(first_bad));
    end
    total++;
    if (fetch_hs !== 16) begin bad++; $display("FAIL t1_fetch_cnt: got %0d want 16", fetch_hs); end
    total++;
    if (out_log.size() !== 16) begin bad++; $display("FAIL t1_out_cnt: got %0d want 16", out_log.size()); end
    first_bad = -1;
    foreach (out_log[i]) if (first_bad < 0 && out_log[i] !== exp_odata(i)) first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL t1_out_seq: word %0d got %h want %h", first_bad, out_log[first_bad], exp_odata(first_bad));
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL t1_done_cnt: got %0d want 1", done_cnt); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_after: got %b want 0", busy); end
    total++;
    if (busy_cycles !== 254) begin bad++; $display("FAIL t1_busy_cycles: got %0d want 254", busy_cycles); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int first_bad;
    clear_logs();
    stall_word = 3;
    stall_left = 5;
    start_job(8'd2, 1'b1);
    repeat (20) @(negedge clk);
    nblk = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_done_timeout: no done within bound, want done"); end
    repeat (3) @(negedge clk);
    total++;
    if (init_cnt !== 1) begin bad++; $display("FAIL t2_busy_start_ignored: init count %0d want 1", init_cnt); end
    total++;
    if (load_log.size() !== 136) begin bad++; $display("FAIL t2_load_cnt: got %0d want 136", load_log.size()); end
    first_bad = -1;
    foreach (load_log[i]) if (first_bad < 0 && load_log[i] !== 16'(i)) first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL t2_load_seq: word %0d got %h want %h", first_bad, load_log[first_bad], 16'(first_bad));
    end
    total++;
    if (src_idx !== 136) begin bad++; $display("FAIL t2_src_consumed: got %0d want 136", src_idx); end
    total++;
    if (stall_samples.size() !== 5) begin bad++; $display("FAIL t2_stall_len: got %0d want 5", stall_samples.size()); end
    first_bad = -1;
    foreach (stall_samples[i]) if (first_bad < 0 && stall_samples[i] !== exp_odata(3)) first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL t2_stall_hold: cycle %0d got %h want %h", first_bad, stall_samples[first_bad], exp_odata(3));
    end
    first_bad = -1;
    foreach (out_log[i]) if (first_bad < 0 && out_log[i] !== exp_odata(i)) first_bad = i;
    total++;
    if (out_log.size() !== 16 || first_bad >= 0) begin
      bad++;
      $display("FAIL t2_out_seq: count %0d first bad %0d want 16 words, none bad", out_log.size(), first_bad);
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL t2_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n0, n1;
    clear_logs();
    ack_block_idx = 10;
    start_job(8'd1, 1'b0);
    n0 = -1;
    for (int i = 0; i < 300; i++) begin
      if (core_load && !core_ack && load_log.size() == 10) begin n0 = cyc; break; end
      @(negedge clk);
    end
    n1 = -1;
    for (int i = 0; i < 400; i++) begin
      if (err) begin n1 = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (n0 < 0 || n1 < 0 || n1 - n0 !== 255) begin
      bad++;
      $display("FAIL t3_err_latency: got %0d cycles want 255 (entry %0d err %0d)", n1 - n0, n0, n1);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({err, busy, core_load, core_fetch, core_init, s_ready} !== 6'b100000) begin
      bad++;
      $display("FAIL t3_err_state: err/busy/load/fetch/init/s_ready=%b want 100000",
               {err, busy, core_load, core_fetch, core_init, s_ready});
    end
    total++;
    if (done_cnt !== 0) begin bad++; $display("FAIL t3_no_done: got %0d want 0", done_cnt); end
    ack_block_idx = -1;
    clear_logs();
    start_job(8'd1, 1'b0);
    total++;
    if ({err, busy} !== 2'b01) begin bad++; $display("FAIL t3_restart: err/busy=%b want 01", {err, busy}); end
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || load_log.size() !== 68 || out_log.size() !== 16 || done_cnt !== 1) begin
      bad++;
      $display("FAIL t3_rerun: done=%b loads=%0d outs=%0d dones=%0d want 1/68/16/1",
               ok, load_log.size(), out_log.size(), done_cnt);
    end
  endtask

  task automatic test_zero_blk();
    clear_logs();
    @(negedge clk);
    nblk = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({done, busy} !== 2'b10) begin bad++; $display("FAIL t4_done_next: done/busy=%b want 10", {done, busy}); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL t4_done_pulse: got %b want 0", done); end
    repeat (4) @(negedge clk);
    total++;
    if (init_cnt + fetch_hs + load_log.size() !== 0 || {core_init, core_load, core_fetch} !== 3'b000) begin
      bad++;
      $display("FAIL t4_no_core: init=%0d loads=%0d fetches=%0d want 0", init_cnt, load_log.size(), fetch_hs);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    int first_bad;
    clear_logs();
    start_job(8'd1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (core_fetch && out_log.size() >= 5) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL t5_reach_fetch: not reached, want FETCH"); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready, m_valid, m_data, busy, done, err, cyc_count, core_init, core_load,
         core_fetch, core_idata} !== '0) begin
      bad++;
      $display("FAIL t5_async_clear: fetch=%b m_data=%h idata=%h want all 0", core_fetch, m_data, core_idata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    start_job(8'd1, 1'b0);
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    first_bad = -1;
    foreach (out_log[i]) if (first_bad < 0 && out_log[i] !== exp_odata(i)) first_bad = i;
    total++;
    if (!ok || init_cnt !== 1 || load_log.size() !== 68 || out_log.size() !== 16 || first_bad >= 0) begin
      bad++;
      $display("FAIL t5_clean_job: done=%b inits=%0d loads=%0d outs=%0d badidx=%0d want 1/1/68/16/-1",
               ok, init_cnt, load_log.size(), out_log.size(), first_bad);
    end
  endtask

  task automatic test_cyc_count();
    bit ok;
    logic [31:0] held;
    clear_logs();
    start_job(8'd1, 1'b0);
    wait_done(2000, ok);
    repeat (2) @(negedge clk);
    total++;
`ifdef KECCAK_SEQ_CTRL_CYCCNT_EN
    if (cyc_count !== 32'(busy_cycles) || busy_cycles !== 254) begin
      bad++;
      $display("FAIL t6_cyc_count: got %0d want %0d (busy cycles, 254)", cyc_count, busy_cycles);
    end
`else
    if (cyc_count !== 32'd0) begin bad++; $display("FAIL t6_cyc_tied: got %0d want 0", cyc_count); end
`endif
    held = cyc_count;
    repeat (5) @(negedge clk);
    total++;
    if (cyc_count !== held) begin bad++; $display("FAIL t6_cyc_frozen: got %0d want %0d", cyc_count, held); end
    clear_logs();
    start_job(8'd1, 1'b0);
    total++;
    if (cyc_count !== 32'd0) begin bad++; $display("FAIL t6_cyc_clear: got %0d want 0", cyc_count); end
    wait_done(2000, ok);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_timeout();
    test_zero_blk();
    test_reset_mid_fetch();
    test_cyc_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
